// File: rtl/snoop_responder.sv
// Snoop-side MSI responder: looks up remote bus requests in a 4-line
// directory, downgrades/invalidates matching lines and supplies M data.
module snoop_responder #(
    parameter logic [1:0] MY_ID  = 2'b00,
    parameter int         DATA_W = 8,
    parameter int         ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_valid,
    output logic              bus_ready,
    input  logic [1:0]        bus_src,
    input  logic [1:0]        bus_cmd,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic              resp_valid,
    input  logic              resp_ack,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_data,
    output logic              abort_mem,
    input  logic              local_we,
    input  logic [ADDR_W-1:0] local_addr,
    input  logic [1:0]        local_state,
    input  logic [DATA_W-1:0] local_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        SUPPLY = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] ST_I    = 2'b00;
    localparam logic [1:0] ST_S    = 2'b01;
    localparam logic [1:0] ST_M    = 2'b10;
    localparam logic [1:0] CMD_RD  = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_INV = 2'b10;
    localparam logic [1:0] CMD_RSV = 2'b11;

    function automatic logic [1:0] blk_of(input logic [ADDR_W-1:0] a);
        logic [1:0] b;
        case (int'(a))
            8, 10:   b = 2'd0;
            12:      b = 2'd1;
            14, 16:  b = 2'd2;
            default: b = 2'd3;
        endcase
        return b;
    endfunction

    state_t              state_q;
    state_t              state_d;

    logic [ADDR_W-1:0]   tag_q  [4];
    logic [1:0]          st_q   [4];
    logic [DATA_W-1:0]   data_q [4];

    logic [1:0]          src_q;
    logic [1:0]          cmd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   sup_data_q;

    logic [1:0]          lk_blk;
    logic [1:0]          lk_st;
    logic                lk_hit;
    logic                lk_sup;
    logic [1:0]          lk_next_st;
    logic [1:0]          lw_blk;
    logic [1:0]          lw_st;

    assign bus_ready = (state_q == IDLE);

    always_comb begin
        lk_blk     = blk_of(addr_q);
        lk_st      = st_q[lk_blk];
        lk_hit     = (lk_st != ST_I) && (tag_q[lk_blk] == addr_q) &&
                     (src_q != MY_ID) && (cmd_q != CMD_RSV);
        lk_sup     = lk_hit && (lk_st == ST_M) && (cmd_q != CMD_INV);
        lk_next_st = lk_st;
        if (lk_hit) begin
            case (cmd_q)
                CMD_RD:  lk_next_st = (lk_st == ST_M) ? ST_S : lk_st;
                CMD_WR:  lk_next_st = ST_I;
                CMD_INV: lk_next_st = ST_I;
                default: lk_next_st = lk_st;
            endcase
        end
        lw_blk = blk_of(local_addr);
        lw_st  = (local_state == 2'b11) ? ST_I : local_state;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus_valid) state_d = LOOKUP;
            LOOKUP:  state_d = lk_sup ? SUPPLY : RESP;
            SUPPLY:  state_d = RESP;
            RESP:    if (resp_valid && resp_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                tag_q[i]  <= '0;
                st_q[i]   <= ST_I;
                data_q[i] <= '0;
            end
            src_q      <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            sup_data_q <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_data  <= '0;
            abort_mem  <= 1'b0;
        end else begin
            if (state_q == IDLE && bus_valid) begin
                src_q  <= bus_src;
                cmd_q  <= bus_cmd;
                addr_q <= bus_addr;
            end
            if (state_q == LOOKUP) begin
                resp_hit   <= lk_hit;
                sup_data_q <= data_q[lk_blk];
                st_q[lk_blk] <= lk_next_st;
            end
            if (state_q == SUPPLY) begin
                resp_data <= sup_data_q;
                abort_mem <= 1'b1;
            end
            if (state_q == RESP) begin
                if (!resp_valid) begin
                    resp_valid <= 1'b1;
                end else if (resp_ack) begin
                    resp_valid <= 1'b0;
                    resp_hit   <= 1'b0;
                    resp_data  <= '0;
                    abort_mem  <= 1'b0;
                end
            end
            // Processor-side write lands last so it overrides a snoop update
            if (local_we) begin
                tag_q[lw_blk]  <= local_addr;
                st_q[lw_blk]   <= lw_st;
                data_q[lw_blk] <= local_data;
            end
        end
    end

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: reference directory model
// feeding a queue of expected responses.
module tb_snoop_responder;

    localparam logic [1:0] MY_ID = 2'b00;

    logic       clock = 1'b0;
    logic       reset;
    logic       bus_valid;
    logic       bus_ready;
    logic [1:0] bus_src;
    logic [1:0] bus_cmd;
    logic [4:0] bus_addr;
    logic       resp_valid;
    logic       resp_ack;
    logic       resp_hit;
    logic [7:0] resp_data;
    logic       abort_mem;
    logic       local_we;
    logic [4:0] local_addr;
    logic [1:0] local_state;
    logic [7:0] local_data;

    always #5 clock = ~clock;

    snoop_responder #(
        .MY_ID (MY_ID),
        .DATA_W(8),
        .ADDR_W(5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_src    (bus_src),
        .bus_cmd    (bus_cmd),
        .bus_addr   (bus_addr),
        .resp_valid (resp_valid),
        .resp_ack   (resp_ack),
        .resp_hit   (resp_hit),
        .resp_data  (resp_data),
        .abort_mem  (abort_mem),
        .local_we   (local_we),
        .local_addr (local_addr),
        .local_state(local_state),
        .local_data (local_data)
    );

    typedef struct {
        logic       hit;
        logic [7:0] data;
        logic       abort;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         chk_cnt = 0;
    int         err_cnt = 0;
    logic [4:0] mtag  [4];
    logic [1:0] mst   [4];
    logic [7:0] mdata [4];
    logic [4:0] atab  [8] = '{5'd8, 5'd10, 5'd12, 5'd14,
                              5'd16, 5'd20, 5'd3, 5'd31};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic int blk(input logic [4:0] a);
        case (a)
            5'd8, 5'd10:  return 0;
            5'd12:        return 1;
            5'd14, 5'd16: return 2;
            default:      return 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mtag[i]  = '0;
            mst[i]   = 2'b00;
            mdata[i] = '0;
        end
    endtask

    task automatic model_write(input logic [4:0] a, input logic [1:0] s,
                               input logic [7:0] d);
        int b;
        b = blk(a);
        mtag[b]  = a;
        mst[b]   = (s == 2'b11) ? 2'b00 : s;
        mdata[b] = d;
    endtask

    task automatic local_wr(input logic [4:0] a, input logic [1:0] s,
                            input logic [7:0] d);
        @(negedge clock);
        local_we    = 1'b1;
        local_addr  = a;
        local_state = s;
        local_data  = d;
        @(posedge clock);
        @(negedge clock);
        local_we = 1'b0;
        model_write(a, s, d);
    endtask

    task automatic do_req(input logic [1:0] src, input logic [1:0] cmd,
                          input logic [4:0] a, input int hold = 0,
                          input bit lw = 0, input logic [1:0] lw_s = 0,
                          input logic [7:0] lw_d = 0);
        exp_t e;
        int   b;
        int   n;
        logic h;
        logic sup;
        b   = blk(a);
        h   = (mst[b] != 2'b00) && (mtag[b] == a) &&
              (src != MY_ID) && (cmd != 2'b11);
        sup = h && (mst[b] == 2'b10) && (cmd != 2'b10);
        e.hit   = h;
        e.data  = sup ? mdata[b] : 8'h00;
        e.abort = sup;
        e.lat   = sup ? 3 : 2;
        sb.push_back(e);
        if (h) begin
            case (cmd)
                2'b00:   if (mst[b] == 2'b10) mst[b] = 2'b01;
                default: mst[b] = 2'b00;
            endcase
        end
        if (lw) model_write(a, lw_s, lw_d);

        @(negedge clock);
        check("ready_idle", bus_ready, 1);
        bus_valid = 1'b1;
        bus_src   = src;
        bus_cmd   = cmd;
        bus_addr  = a;
        @(posedge clock);
        @(negedge clock);
        bus_valid = 1'b0;
        if (lw) begin
            local_we    = 1'b1;
            local_addr  = a;
            local_state = lw_s;
            local_data  = lw_d;
        end
        n = 0;
        while (!resp_valid && n < 10) begin
            @(posedge clock);
            @(negedge clock);
            local_we = 1'b0;
            n++;
        end
        e = sb.pop_front();
        check("resp_valid", resp_valid, 1);
        check("latency", n, e.lat);
        check("resp_hit", resp_hit, e.hit);
        check("resp_data", resp_data, e.data);
        check("abort_mem", abort_mem, e.abort);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("hold_valid", resp_valid, 1);
            check("hold_ready", bus_ready, 0);
        end
        resp_ack = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ack = 1'b0;
        check("post_valid", resp_valid, 0);
        check("post_hit", resp_hit, 0);
        check("post_data", resp_data, 0);
        check("post_abort", abort_mem, 0);
        check("post_ready", bus_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        bus_valid   = 1'b0;
        bus_src     = '0;
        bus_cmd     = '0;
        bus_addr    = '0;
        resp_ack    = 1'b0;
        local_we    = 1'b0;
        local_addr  = '0;
        local_state = '0;
        local_data  = '0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_ready", bus_ready, 1);
        check("rst_valid", resp_valid, 0);
        check("rst_hit", resp_hit, 0);
        check("rst_data", resp_data, 0);
        check("rst_abort", abort_mem, 0);

        do_req(2'd1, 2'b00, 5'd8);

        local_wr(5'd12, 2'b10, 8'hA5);
        do_req(2'd2, 2'b00, 5'd12);
        do_req(2'd3, 2'b00, 5'd12);

        local_wr(5'd14, 2'b01, 8'h11);
        do_req(2'd1, 2'b01, 5'd16);
        do_req(2'd1, 2'b01, 5'd14);
        do_req(2'd2, 2'b00, 5'd14);

        local_wr(5'd10, 2'b10, 8'h42);
        do_req(MY_ID, 2'b10, 5'd10, 5);
        do_req(2'd1, 2'b10, 5'd10);
        do_req(2'd1, 2'b00, 5'd10);

        local_wr(5'd8, 2'b10, 8'h9E);
        do_req(2'd2, 2'b11, 5'd8);
        do_req(2'd2, 2'b01, 5'd8);

        local_wr(5'd20, 2'b10, 8'h3C);
        do_req(2'd1, 2'b00, 5'd20, 0, 1'b1, 2'b01, 8'h77);
        do_req(2'd2, 2'b00, 5'd20);
        do_req(2'd2, 2'b00, 5'd21);
        local_wr(5'd20, 2'b11, 8'h01);
        do_req(2'd2, 2'b00, 5'd20);

        for (int k = 0; k < 40; k++) begin
            logic [4:0] a;
            a = atab[$urandom_range(7)];
            if ($urandom_range(1) == 0) begin
                local_wr(a, 2'($urandom_range(3)), 8'($urandom));
            end else begin
                do_req(2'($urandom_range(3)), 2'($urandom_range(3)), a);
            end
        end

        local_wr(5'd12, 2'b10, 8'h5A);
        @(negedge clock);
        bus_valid = 1'b1;
        bus_src   = 2'd1;
        bus_cmd   = 2'b00;
        bus_addr  = 5'd12;
        @(posedge clock);
        @(negedge clock);
        bus_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("sup_hit_pre", resp_hit, 1);
        reset = 1'b0;
        #1;
        check("arst_ready", bus_ready, 1);
        check("arst_valid", resp_valid, 0);
        check("arst_hit", resp_hit, 0);
        check("arst_data", resp_data, 0);
        check("arst_abort", abort_mem, 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("arst_no_resp", resp_valid, 0);
        end
        do_req(2'd1, 2'b00, 5'd12);
        do_req(2'd1, 2'b00, 5'd20);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
